// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: one outstanding memory request, 2-entry
// {PC, instruction} queue toward decode, PC advance strobe upstream.
module instr_fetch_unit #(
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32,
  parameter int ALIGN   = 2
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [ADDR_W-1:0]  PC,
  output logic               PCAdvance,
  input  logic               Flush,
  output logic               MemReq,
  output logic [ADDR_W-1:0]  MemAddr,
  input  logic               MemAck,
  input  logic [INSTR_W-1:0] MemData,
  output logic               InstrValid,
  output logic [INSTR_W-1:0] Instr,
  output logic [ADDR_W-1:0]  InstrPC,
  input  logic               InstrReady,
  output logic               Fault
);

  typedef enum logic [1:0] {
    S_IDLE, S_WAIT, S_ADV, S_DROP
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               fault_q, fault_d;
  logic [1:0]         count_q, count_d;
  logic               rd_q, rd_d;
  logic               wr_q, wr_d;
  logic [ADDR_W-1:0]  qpc_q [2];
  logic [ADDR_W-1:0]  qpc_d [2];
  logic [INSTR_W-1:0] qins_q [2];
  logic [INSTR_W-1:0] qins_d [2];

  logic misaligned;
  logic issue;
  logic push;
  logic pop;

  assign misaligned = |PC[ALIGN-1:0];

  // State register
  always_ff @(posedge Clock) begin
    if (Reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; DROP absorbs the ack of a flushed request
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (!Flush && !fault_q && !misaligned && count_q != 2'd2)
          state_d = S_WAIT;
      end
      S_WAIT: begin
        if (MemAck)     state_d = Flush ? S_IDLE : S_ADV;
        else if (Flush) state_d = S_DROP;
      end
      S_ADV:  state_d = S_IDLE;
      S_DROP: begin
        if (MemAck) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state; reset suppresses a pending advance
  always_comb begin
    MemReq    = (state_q == S_WAIT) || (state_q == S_DROP);
    PCAdvance = (state_q == S_ADV) && !Flush && !Reset;
  end

  assign issue      = (state_q == S_IDLE) && (state_d == S_WAIT);
  assign push       = (state_q == S_WAIT) && MemAck && !Flush;
  assign InstrValid = (count_q != 2'd0);
  assign pop        = InstrValid && InstrReady && !Flush;

  assign MemAddr = addr_q;
  assign Fault   = fault_q;
  assign Instr   = InstrValid ? qins_q[rd_q] : '0;
  assign InstrPC = InstrValid ? qpc_q[rd_q] : '0;

  // Request address capture and sticky misalignment fault
  always_comb begin
    addr_d  = issue ? PC : addr_q;
    fault_d = fault_q;
    if (Flush)
      fault_d = 1'b0;
    else if (state_q == S_IDLE && !fault_q && misaligned)
      fault_d = 1'b1;
  end

  // Queue bookkeeping; flush empties it and overrides any pop
  always_comb begin
    qpc_d   = qpc_q;
    qins_d  = qins_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    if (Flush) begin
      rd_d    = 1'b0;
      wr_d    = 1'b0;
      count_d = 2'd0;
    end else begin
      if (push) begin
        qpc_d[wr_q]  = addr_q;
        qins_d[wr_q] = MemData;
        wr_d         = ~wr_q;
      end
      if (pop) rd_d = ~rd_q;
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // Datapath registers
  always_ff @(posedge Clock) begin
    if (Reset) begin
      addr_q  <= '0;
      fault_q <= 1'b0;
      count_q <= 2'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      qpc_q   <= '{default: '0};
      qins_q  <= '{default: '0};
    end else begin
      addr_q  <= addr_d;
      fault_q <= fault_d;
      count_q <= count_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      qpc_q   <= qpc_d;
      qins_q  <= qins_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: memory responder,
// upstream PC register model and {PC, instr} scoreboard.
module tb_instr_fetch_unit;

  localparam int AW = 64;
  localparam int IW = 32;

  logic          Clock;
  logic          Reset;
  logic [AW-1:0] PC;
  logic          PCAdvance;
  logic          Flush;
  logic          MemReq;
  logic [AW-1:0] MemAddr;
  logic          MemAck;
  logic [IW-1:0] MemData;
  logic          InstrValid;
  logic [IW-1:0] Instr;
  logic [AW-1:0] InstrPC;
  logic          InstrReady;
  logic          Fault;

  instr_fetch_unit #(.ADDR_W(AW), .INSTR_W(IW), .ALIGN(2)) dut (
    .Clock(Clock), .Reset(Reset), .PC(PC), .PCAdvance(PCAdvance),
    .Flush(Flush), .MemReq(MemReq), .MemAddr(MemAddr),
    .MemAck(MemAck), .MemData(MemData), .InstrValid(InstrValid),
    .Instr(Instr), .InstrPC(InstrPC), .InstrReady(InstrReady),
    .Fault(Fault)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic [AW+IW-1:0] sb [$];
  int checks = 0;
  int fails = 0;
  int cyc = 0;
  int adv_count = 0;
  int adv_cyc = -1;
  int ack_cyc = -1;
  int rise_cyc = -1;
  int req_rises = 0;
  int pops = 0;
  int age = 0;
  int lat = 1;
  int step = 4;
  bit auto_ack = 0;
  bit req_prev = 0;
  bit dropping = 0;

  function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
    return a[31:0] ^ 32'h5A00_00C3 ^ {a[15:0], a[31:16]};
  endfunction

  // One clock: observe at negedge, drive at posedge+1
  task automatic cycle();
    logic [AW+IW-1:0] exp;
    bit adv_now;
    bit ack_next;
    logic [IW-1:0] data_next;
    @(negedge Clock);
    cyc++;
    if (PCAdvance) begin
      adv_count++;
      adv_cyc = cyc;
    end
    if (MemReq && !req_prev) begin
      req_rises++;
      rise_cyc = cyc;
    end
    req_prev = MemReq;
    if (Reset) begin
      sb.delete();
      dropping = 0;
    end else begin
      if (InstrValid && InstrReady && !Flush) begin
        checks++;
        pops++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL pop_empty: got pc=%h instr=%h, none expected",
                   InstrPC, Instr);
        end else begin
          exp = sb.pop_front();
          if ({InstrPC, Instr} !== exp) begin
            fails++;
            $display("FAIL pop_data: got pc=%h instr=%h, want pc=%h instr=%h",
                     InstrPC, Instr, exp[AW+IW-1:IW], exp[IW-1:0]);
          end
        end
      end
      if (Flush) sb.delete();
      if (MemReq && MemAck) begin
        ack_cyc = cyc;
        if (!Flush && !dropping) sb.push_back({MemAddr, MemData});
        dropping = 0;
      end else if (MemReq && Flush) begin
        dropping = 1;
      end
    end
    if (MemReq && !MemAck) age++;
    else age = 0;
    ack_next  = auto_ack && MemReq && !MemAck && (age == lat);
    data_next = mem_word(MemAddr);
    adv_now   = PCAdvance;
    @(posedge Clock);
    #1;
    if (adv_now) PC = PC + AW'(step);
    if (auto_ack) begin
      MemAck  = ack_next;
      MemData = ack_next ? data_next : '0;
    end
  endtask

  task automatic do_reset();
    Reset = 1;
    Flush = 0;
    MemAck = 0;
    MemData = '0;
    auto_ack = 0;
    InstrReady = 0;
    cycle();
    Reset = 0;
    adv_count = 0;
    req_rises = 0;
    pops = 0;
    req_prev = 0;
    age = 0;
  endtask

  task automatic wait_req(input int budget, input string nm);
    int n;
    n = 0;
    while (!MemReq && n < budget) begin
      cycle();
      n++;
    end
    checks++;
    if (!MemReq) begin
      fails++;
      $display("FAIL %s: MemReq=0 after %0d cycles, want 1", nm, budget);
    end
  endtask

  task automatic test_reset();
    Reset = 1;
    cycle();
    cycle();
    checks++;
    if ({MemReq, MemAddr, PCAdvance, InstrValid, Instr, InstrPC, Fault} !== '0) begin
      fails++;
      $display("FAIL reset_outs: req=%b addr=%h adv=%b v=%b i=%h ipc=%h f=%b, want all 0",
               MemReq, MemAddr, PCAdvance, InstrValid, Instr, InstrPC, Fault);
    end
    Reset = 0;
  endtask

  task automatic test_basic();
    int n;
    do_reset();
    PC = '0;
    step = 4;
    lat = 2;
    auto_ack = 1;
    InstrReady = 1;
    wait_req(5, "basic_req");
    checks++;
    if (MemAddr !== 64'h0) begin
      fails++;
      $display("FAIL basic_addr0: got %h want 0", MemAddr);
    end
    n = 0;
    while (req_rises < 2 && n < 20) begin
      cycle();
      n++;
    end
    checks++;
    if (adv_cyc != ack_cyc + 1 || rise_cyc != ack_cyc + 3) begin
      fails++;
      $display("FAIL basic_timing: ack=%0d adv=%0d rise=%0d, want adv=ack+1 rise=ack+3",
               ack_cyc, adv_cyc, rise_cyc);
    end
    checks++;
    if (adv_count != 1 || pops != 1) begin
      fails++;
      $display("FAIL basic_counts: adv=%0d pops=%0d, want 1 and 1", adv_count, pops);
    end
    checks++;
    if (!MemReq || MemAddr !== 64'h4) begin
      fails++;
      $display("FAIL basic_addr1: req=%b addr=%h, want 1 and 4", MemReq, MemAddr);
    end
  endtask

  task automatic test_fill();
    do_reset();
    PC = '0;
    step = 8;
    lat = 1;
    auto_ack = 1;
    repeat (30) cycle();
    checks++;
    if (req_rises != 2 || MemReq !== 1'b0) begin
      fails++;
      $display("FAIL fill_stall: reqs=%0d req=%b, want 2 and 0", req_rises, MemReq);
    end
    checks++;
    if (InstrValid !== 1'b1 || InstrPC !== 64'h0 || PC !== 64'h10) begin
      fails++;
      $display("FAIL fill_head: v=%b ipc=%h pc=%h, want 1 0 10",
               InstrValid, InstrPC, PC);
    end
    InstrReady = 1;
    cycle();
    InstrReady = 0;
    wait_req(6, "fill_refetch");
    repeat (6) cycle();
    checks++;
    if (req_rises != 3 || MemReq !== 1'b0) begin
      fails++;
      $display("FAIL fill_refill: reqs=%0d req=%b, want 3 and 0", req_rises, MemReq);
    end
    auto_ack = 0;
    MemAck = 0;
    InstrReady = 1;
    repeat (8) cycle();
    checks++;
    if (pops != 3 || InstrValid !== 1'b0) begin
      fails++;
      $display("FAIL fill_drain: pops=%0d v=%b, want 3 and 0", pops, InstrValid);
    end
    checks++;
    if (!MemReq || MemAddr !== 64'h18) begin
      fails++;
      $display("FAIL fill_next: req=%b addr=%h, want 1 and 18", MemReq, MemAddr);
    end
  endtask

  task automatic test_flush_wait();
    do_reset();
    PC = 64'h100;
    step = 4;
    InstrReady = 1;
    wait_req(5, "fw_req");
    cycle();
    Flush = 1;
    cycle();
    Flush = 0;
    cycle();
    checks++;
    if (MemReq !== 1'b1) begin
      fails++;
      $display("FAIL fw_drop_hold: req=%b want 1", MemReq);
    end
    cycle();
    MemAck = 1;
    MemData = mem_word(64'h100);
    cycle();
    MemAck = 0;
    MemData = '0;
    checks++;
    if (MemReq !== 1'b0 || InstrValid !== 1'b0) begin
      fails++;
      $display("FAIL fw_after_ack: req=%b v=%b, want 0 0", MemReq, InstrValid);
    end
    wait_req(5, "fw_refetch");
    checks++;
    if (MemAddr !== 64'h100 || adv_count != 0 || InstrValid !== 1'b0) begin
      fails++;
      $display("FAIL fw_state: addr=%h adv=%0d v=%b, want 100 0 0",
               MemAddr, adv_count, InstrValid);
    end
  endtask

  task automatic test_flush_ack();
    do_reset();
    PC = 64'h200;
    InstrReady = 1;
    wait_req(5, "fa_req");
    MemAck = 1;
    MemData = mem_word(64'h200);
    Flush = 1;
    cycle();
    MemAck = 0;
    Flush = 0;
    checks++;
    if (MemReq !== 1'b0 || PCAdvance !== 1'b0 || InstrValid !== 1'b0) begin
      fails++;
      $display("FAIL fa_idle: req=%b adv=%b v=%b, want 0 0 0",
               MemReq, PCAdvance, InstrValid);
    end
    cycle();
    checks++;
    if (!MemReq || MemAddr !== 64'h200 || adv_count != 0) begin
      fails++;
      $display("FAIL fa_refetch: req=%b addr=%h adv=%0d, want 1 200 0",
               MemReq, MemAddr, adv_count);
    end
  endtask

  task automatic test_fault();
    do_reset();
    PC = 64'h6;
    repeat (4) cycle();
    checks++;
    if (Fault !== 1'b1 || req_rises != 0) begin
      fails++;
      $display("FAIL fault_set: fault=%b reqs=%0d, want 1 0", Fault, req_rises);
    end
    PC = 64'h10;
    repeat (2) cycle();
    checks++;
    if (Fault !== 1'b1 || MemReq !== 1'b0) begin
      fails++;
      $display("FAIL fault_sticky: fault=%b req=%b, want 1 0", Fault, MemReq);
    end
    Flush = 1;
    cycle();
    Flush = 0;
    checks++;
    if (Fault !== 1'b0 || MemReq !== 1'b0) begin
      fails++;
      $display("FAIL fault_clear: fault=%b req=%b, want 0 0", Fault, MemReq);
    end
    cycle();
    checks++;
    if (!MemReq || MemAddr !== 64'h10) begin
      fails++;
      $display("FAIL fault_resume: req=%b addr=%h, want 1 10", MemReq, MemAddr);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    PC = 64'h300;
    wait_req(5, "rm_req");
    Reset = 1;
    cycle();
    Reset = 0;
    checks++;
    if ({MemReq, MemAddr, PCAdvance, InstrValid, Instr, InstrPC, Fault} !== '0) begin
      fails++;
      $display("FAIL rm_wait_outs: req=%b addr=%h adv=%b v=%b, want all 0",
               MemReq, MemAddr, PCAdvance, InstrValid);
    end
    MemAck = 1;
    MemData = mem_word(64'h300);
    cycle();
    MemAck = 0;
    cycle();
    checks++;
    if (!MemReq || MemAddr !== 64'h300 || InstrValid !== 1'b0) begin
      fails++;
      $display("FAIL rm_late_ack: req=%b addr=%h v=%b, want 1 300 0",
               MemReq, MemAddr, InstrValid);
    end
    MemAck = 1;
    cycle();
    MemAck = 0;
    MemData = '0;
    Reset = 1;
    cycle();
    Reset = 0;
    checks++;
    if ({MemReq, MemAddr, PCAdvance, InstrValid, Instr, InstrPC, Fault} !== '0) begin
      fails++;
      $display("FAIL rm_adv_outs: req=%b addr=%h v=%b i=%h ipc=%h, want all 0",
               MemReq, MemAddr, InstrValid, Instr, InstrPC);
    end
    checks++;
    if (adv_count != 0 || PC !== 64'h300) begin
      fails++;
      $display("FAIL rm_no_adv: adv=%0d pc=%h, want 0 300", adv_count, PC);
    end
  endtask

  initial begin
    Reset = 1;
    PC = '0;
    Flush = 0;
    MemAck = 0;
    MemData = '0;
    InstrReady = 0;
    test_reset();
    test_basic();
    test_fill();
    test_flush_wait();
    test_flush_ack();
    test_fault();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
